seq_pattern_driver: RTL and testbench

Serial stimulus driver and response checker for the two-bit sequence machine (input `x`, state `y1`/`y2`, outputs `z1`/`z2`). It accepts parallel pattern words over a valid/ready handshake and shifts them out MSB-first on `x_out`, one bit per clock. It runs a cycle-exact internal model of the machine, compares the returned `z1`/`z2` every shifting cycle, and keeps a saturating mismatch count. It sits on the driving side of the machine's interface in self-checking test harnesses and in built-in self-test wrappers.

---
 rtl/seq_pattern_driver.sv | 122 ++++++++++++
 tb/tb_seq_pattern_driver.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/seq_pattern_driver.sv
// Serial pattern driver for the two-bit sequence machine: shifts words out MSB-first on x_out,
// runs a cycle-exact model of the machine and counts response mismatches.
module seq_pattern_driver #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             x_out,
  input  logic             z1_in,
  input  logic             z2_in,
  input  logic             err_clr,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [CNT_W-1:0] err_count,
  output logic [1:0]       model_y
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] shift_reg, shift_next;
  logic [CW-1:0]    cnt_reg, cnt_next;
  logic             x_out_reg, x_out_next;
  logic             done_reg, done_next;
  logic             err_reg, err_next;
  logic [CNT_W-1:0] err_count_reg, err_count_next;
  logic [1:0]       model_y_reg, model_y_next;
  logic             mismatch;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      shift_reg     <= '0;
      cnt_reg       <= '0;
      x_out_reg     <= 1'b0;
      done_reg      <= 1'b0;
      err_reg       <= 1'b0;
      err_count_reg <= '0;
      model_y_reg   <= 2'b00;
    end else begin
      state_reg     <= state_next;
      shift_reg     <= shift_next;
      cnt_reg       <= cnt_next;
      x_out_reg     <= x_out_next;
      done_reg      <= done_next;
      err_reg       <= err_next;
      err_count_reg <= err_count_next;
      model_y_reg   <= model_y_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    shift_next = shift_reg;
    cnt_next   = cnt_reg;
    x_out_next = x_out_reg;
    done_next  = 1'b0;
    in_ready   = 1'b0;
    busy       = 1'b0;
    case (state_reg)
      IDLE: begin
        in_ready   = 1'b1;
        x_out_next = 1'b0;
        if (in_valid) begin
          shift_next = in_data;
          x_out_next = in_data[WIDTH-1];
          cnt_next   = '0;
          state_next = SHIFT;
        end
      end
      SHIFT: begin
        busy       = 1'b1;
        // x_out_reg already holds the MSB, so the next bit out is one below it.
        shift_next = shift_reg << 1;
        x_out_next = shift_reg[WIDTH-2];
        cnt_next   = cnt_reg + 1'b1;
        if (cnt_reg == CW'(WIDTH-1)) begin
          state_next = IDLE;
          x_out_next = 1'b0;
          done_next  = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // The machine is clocked continuously, so the model also advances on idle cycles.
  always_comb begin
    model_y_next[1] = (x_out_reg & ~model_y_reg[1]) |
                      ((x_out_reg ^ model_y_reg[0]) & model_y_reg[1]);
    model_y_next[0] = ~model_y_reg[1] & (~x_out_reg | ~model_y_reg[0]);
  end

  always_comb begin
    mismatch = (state_reg == SHIFT) &&
               ((z1_in != (model_y_reg[1] & model_y_reg[0])) || (z2_in != ~x_out_reg));
    err_count_next = err_count_reg;
    err_next       = err_reg;
    if (err_clr) begin
      err_count_next = '0;
      err_next       = 1'b0;
    end else if (mismatch) begin
      err_next = 1'b1;
      if (err_count_reg != '1)
        err_count_next = err_count_reg + 1'b1;
    end
  end

  assign x_out     = x_out_reg;
  assign done      = done_reg;
  assign err       = err_reg;
  assign err_count = err_count_reg;
  assign model_y   = model_y_reg;

endmodule

// File: tb/tb_seq_pattern_driver.sv
// Self-checking bench for seq_pattern_driver: per-cycle expectations queued on each accepted word.
module tb_seq_pattern_driver;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic [W-1:0] in_data = '0;
  logic         z1_in = 1'b0;
  logic         z2_in = 1'b0;
  logic         err_clr = 1'b0;
  logic         in_ready, x_out, busy, done, err;
  logic [7:0]   err_count;
  logic [1:0]   model_y;
  logic         in_ready_s, x_out_s, busy_s, done_s, err_s;
  logic [3:0]   err_count_s;
  logic [1:0]   model_y_s;

  seq_pattern_driver #(.WIDTH(W), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .x_out(x_out), .z1_in(z1_in), .z2_in(z2_in), .err_clr(err_clr), .busy(busy),
    .done(done), .err(err), .err_count(err_count), .model_y(model_y)
  );

  // Narrow-counter instance sharing all inputs, used for the saturation check.
  seq_pattern_driver #(.WIDTH(W), .CNT_W(4)) dut_s (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_s), .in_data(in_data),
    .x_out(x_out_s), .z1_in(z1_in), .z2_in(z2_in), .err_clr(err_clr), .busy(busy_s),
    .done(done_s), .err(err_s), .err_count(err_count_s), .model_y(model_y_s)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic x;
    logic busy;
    logic done;
  } exp_t;

  exp_t       exp_q[$];
  int         checks = 0;
  int         errors = 0;
  logic [1:0] mdl_y = 2'b00;
  int         exp_cnt = 0;
  int         exp_cnt_s = 0;
  logic       exp_err = 1'b0;
  logic       z1_force = 1'b0;
  logic       z2_inv = 1'b0;
  int         done_seen = 0;
  int         accepts = 0;

  // Transition table of the machine, indexed by {y1,y2,x}.
  function automatic logic [1:0] mdl_next(input logic x, input logic [1:0] y);
    case ({y, x})
      3'b000: return 2'b01;
      3'b001: return 2'b11;
      3'b010: return 2'b01;
      3'b011: return 2'b10;
      3'b100: return 2'b00;
      3'b101: return 2'b10;
      3'b110: return 2'b10;
      default: return 2'b00;
    endcase
  endfunction

  // One clock cycle, entered and left at a falling edge.
  task automatic step();
    exp_t e;
    logic z1c, z2c, mis;
    e = '0;
    if (exp_q.size() > 0) e = exp_q.pop_front();
    checks++; if (x_out !== e.x) begin errors++; $display("FAIL x_out got %b want %b t=%0t", x_out, e.x, $time); end
    checks++; if (x_out_s !== e.x) begin errors++; $display("FAIL x_out_s got %b want %b t=%0t", x_out_s, e.x, $time); end
    checks++; if (busy !== e.busy) begin errors++; $display("FAIL busy got %b want %b t=%0t", busy, e.busy, $time); end
    checks++; if (in_ready !== ~e.busy) begin errors++; $display("FAIL in_ready got %b want %b t=%0t", in_ready, ~e.busy, $time); end
    checks++; if (done !== e.done) begin errors++; $display("FAIL done got %b want %b t=%0t", done, e.done, $time); end
    checks++; if (model_y !== mdl_y) begin errors++; $display("FAIL model_y got %b want %b t=%0t", model_y, mdl_y, $time); end
    checks++; if (err_count !== 8'(exp_cnt)) begin errors++; $display("FAIL err_count got %0d want %0d t=%0t", err_count, exp_cnt, $time); end
    checks++; if (err_count_s !== 4'(exp_cnt_s)) begin errors++; $display("FAIL err_count_s got %0d want %0d t=%0t", err_count_s, exp_cnt_s, $time); end
    checks++; if (err !== exp_err) begin errors++; $display("FAIL err got %b want %b t=%0t", err, exp_err, $time); end
    if (done) done_seen++;
    z1c = mdl_y[1] & mdl_y[0];
    z2c = ~e.x;
    z1_in = z1_force ? 1'b0 : z1c;
    z2_in = z2_inv ? ~z2c : z2c;
    mis = e.busy && ((z1_in != z1c) || (z2_in != z2c));
    if (err_clr) begin
      exp_cnt = 0; exp_cnt_s = 0; exp_err = 1'b0;
    end else if (mis) begin
      if (exp_cnt < 255) exp_cnt++;
      if (exp_cnt_s < 15) exp_cnt_s++;
      exp_err = 1'b1;
    end
    if (in_valid && !e.busy) begin
      accepts++;
      $display("accept word %h at t=%0t", in_data, $time);
      for (int i = W - 1; i >= 0; i--) exp_q.push_back('{x: in_data[i], busy: 1'b1, done: 1'b0});
      exp_q.push_back('{x: 1'b0, busy: 1'b0, done: 1'b1});
    end
    mdl_y = mdl_next(e.x, mdl_y);
    @(negedge clk);
  endtask

  task automatic test_reset();
    #1;
    checks++; if (in_ready !== 1'b1 || x_out !== 1'b0 || busy !== 1'b0 || done !== 1'b0)
      begin errors++; $display("FAIL reset_outputs got rdy=%b x=%b busy=%b done=%b want 1 0 0 0", in_ready, x_out, busy, done); end
    checks++; if (err_count !== 8'd0 || err !== 1'b0 || model_y !== 2'b00)
      begin errors++; $display("FAIL reset_err got cnt=%0d err=%b y=%b want 0 0 00", err_count, err, model_y); end
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    repeat (3) step();
  endtask

  task automatic test_all_ones();
    done_seen = 0;
    in_data = 8'hFF; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    repeat (W) step();
    // Next word goes in on the done cycle, leaving the model at 00 for its first bit.
    in_data = 8'hE0; in_valid = 1'b1; z1_force = 1'b1;
    step();
    in_valid = 1'b0;
    checks++; if (done_seen !== 1) begin errors++; $display("FAIL done_count got %0d want 1", done_seen); end
  endtask

  task automatic test_z1_mismatch();
    repeat (W) step();
    z1_force = 1'b0;
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL z1_err got %b want 1", err); end
    checks++; if (err_count !== 8'd2) begin errors++; $display("FAIL z1_count got %0d want 2", err_count); end
    step();
  endtask

  task automatic test_double_clear();
    err_clr = 1'b1; step(); err_clr = 1'b0;
    in_data = 8'hAA; in_valid = 1'b1; z2_inv = 1'b1;
    step();
    in_valid = 1'b0;
    repeat (W) step();
    checks++; if (err_count !== 8'd8) begin errors++; $display("FAIL z2_count got %0d want 8", err_count); end
    in_data = 8'h55; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step(); step();
    err_clr = 1'b1; step(); err_clr = 1'b0;
    checks++; if (err_count !== 8'd0 || err !== 1'b0) begin errors++; $display("FAIL clr_collision got cnt=%0d err=%b want 0 0", err_count, err); end
    repeat (W - 3) step();
    checks++; if (err_count !== 8'd5) begin errors++; $display("FAIL after_clr got %0d want 5", err_count); end
    z2_inv = 1'b0;
    step();
  endtask

  task automatic test_saturation();
    err_clr = 1'b1; step(); err_clr = 1'b0;
    z2_inv = 1'b1;
    for (int w = 0; w < 3; w++) begin
      in_data = W'($urandom); in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      repeat (W) step();
    end
    checks++; if (err_count_s !== 4'd15) begin errors++; $display("FAIL sat4 got %0d want 15", err_count_s); end
    checks++; if (err_count !== 8'd24) begin errors++; $display("FAIL sat8 got %0d want 24", err_count); end
    z2_inv = 1'b0;
    step();
  endtask

  task automatic test_reset_midword();
    in_data = 8'hA5; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    repeat (5) step();
    #2 rst_n = 1'b0;
    #1;
    checks++; if (x_out !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0)
      begin errors++; $display("FAIL midreset got x=%b rdy=%b busy=%b done=%b want 0 1 0 0", x_out, in_ready, busy, done); end
    checks++; if (err_count !== 8'd0 || model_y !== 2'b00)
      begin errors++; $display("FAIL midreset_state got cnt=%0d y=%b want 0 00", err_count, model_y); end
    exp_q.delete();
    mdl_y = 2'b00; exp_cnt = 0; exp_cnt_s = 0; exp_err = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    done_seen = 0;
    repeat (W + 2) step();
    checks++; if (done_seen !== 0) begin errors++; $display("FAIL aborted_done got %0d want 0", done_seen); end
  endtask

  task automatic test_back_to_back();
    accepts = 0;
    in_valid = 1'b1;
    repeat (2 * (W + 1)) begin
      in_data = W'($urandom);
      step();
    end
    in_valid = 1'b0;
    repeat (3) step();
    checks++; if (accepts !== 2) begin errors++; $display("FAIL held_valid_accepts got %0d want 2", accepts); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_all_ones();
    test_z1_mismatch();
    test_double_clear();
    test_saturation();
    test_reset_midword();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
